// File: rtl/morse_pkg.sv
// Shared Morse definitions: code table A-H, symbol/letter widths, decoder FSM states.
// Latency: none (declarations only).
// Backpressure: none; used by both transmitter and decoder so they agree on one table.
package morse_pkg;

  localparam int CODE_WIDTH    = 12;
  localparam int LETTER_WIDTH  = 3;
  localparam int BIT_CNT_WIDTH = 4;

  typedef logic [CODE_WIDTH-1:0]   code_t;
  typedef logic [LETTER_WIDTH-1:0] letter_t;

  // Dot = 10, dash = 1110, MSB first, right-padded with idle zeros.
  localparam code_t CODE_A = 12'b101110000000;
  localparam code_t CODE_B = 12'b111010101000;
  localparam code_t CODE_C = 12'b111010111010;
  localparam code_t CODE_D = 12'b111010100000;
  localparam code_t CODE_E = 12'b100000000000;
  localparam code_t CODE_F = 12'b101011101000;
  localparam code_t CODE_G = 12'b111011101000;
  localparam code_t CODE_H = 12'b101010100000;

  localparam letter_t LETTER_A = 3'd0;
  localparam letter_t LETTER_B = 3'd1;
  localparam letter_t LETTER_C = 3'd2;
  localparam letter_t LETTER_D = 3'd3;
  localparam letter_t LETTER_E = 3'd4;
  localparam letter_t LETTER_F = 3'd5;
  localparam letter_t LETTER_G = 3'd6;
  localparam letter_t LETTER_H = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MATCH = 2'd2
  } state_t;

endpackage

// File: rtl/morse_code_lookup.sv
// Maps a complete 12-bit Morse symbol to its letter code and a hit flag.
// Latency: purely combinational.
// Backpressure: none.
module morse_code_lookup
  import morse_pkg::*;
(
  input  code_t   code,
  output logic    hit,
  output letter_t letter
);

  // Table match; anything outside A-H reports a miss with letter forced to 0.
  always_comb begin
    hit    = 1'b1;
    letter = LETTER_A;
    case (code)
      CODE_A:  letter = LETTER_A;
      CODE_B:  letter = LETTER_B;
      CODE_C:  letter = LETTER_C;
      CODE_D:  letter = LETTER_D;
      CODE_E:  letter = LETTER_E;
      CODE_F:  letter = LETTER_F;
      CODE_G:  letter = LETTER_G;
      CODE_H:  letter = LETTER_H;
      default: hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Assembles strobed dot/dash bits into 12-bit symbols and decodes them to letters A-H.
// Latency: LetterValid/CodeError two cycles after the 12th strobe; timeout TIMEOUT_CYCLES+1 after last strobe.
// Backpressure: none; strobes arriving in MATCH are dropped, a new symbol may start in the result cycle.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY
) (
  input  logic                    ClockIn,
  input  logic                    Reset,
  input  logic                    DotDashIn,
  input  logic                    NewBitIn,
  output logic [LETTER_WIDTH-1:0] LetterOut,
  output logic                    LetterValid,
  output logic                    CodeError,
  output logic                    Busy
);

  localparam int GAP_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GAP_WIDTH-1:0]     GAP_MAX  = GAP_WIDTH'(TIMEOUT_CYCLES);
  // Deciding one count early lets the registered error land exactly TIMEOUT_CYCLES+1 after the last strobe.
  localparam logic [GAP_WIDTH-1:0]     GAP_LAST = GAP_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_WIDTH-1:0]     GAP_ONE  = GAP_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0] CNT_LAST = BIT_CNT_WIDTH'(CODE_WIDTH - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] CNT_FULL = BIT_CNT_WIDTH'(CODE_WIDTH);
  localparam logic [BIT_CNT_WIDTH-1:0] CNT_ONE  = BIT_CNT_WIDTH'(1);
  localparam code_t                    CODE_START = {{(CODE_WIDTH-1){1'b0}}, 1'b1};

  if (TIMEOUT_CYCLES < 1 || CLOCK_FREQUENCY < 1) begin : g_param_check
    $error("morse_decoder: TIMEOUT_CYCLES and CLOCK_FREQUENCY must be positive");
  end

  state_t                   state_q;
  state_t                   state_d;
  code_t                    shift_q;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt_q;
  logic [GAP_WIDTH-1:0]     gap_q;

  logic    start_bit;
  logic    timeout;
  logic    lookup_hit;
  letter_t lookup_letter;
  logic    letter_vld_d;
  logic    code_err_d;

  assign start_bit = NewBitIn & DotDashIn;
  assign timeout   = (state_q == SHIFT) & ~NewBitIn & (gap_q >= GAP_LAST);

  morse_code_lookup u_lookup (
    .code   (shift_q),
    .hit    (lookup_hit),
    .letter (lookup_letter)
  );

  // State register.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start on a 1 strobe, finish on the 12th bit or on gap timeout, MATCH lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_bit) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (NewBitIn) begin
          if (bit_cnt_q == CNT_LAST) begin
            state_d = MATCH;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      MATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: next values of the result pulses, registered below.
  always_comb begin
    letter_vld_d = 1'b0;
    code_err_d   = 1'b0;
    case (state_q)
      MATCH: begin
        letter_vld_d = lookup_hit;
        code_err_d   = ~lookup_hit;
      end
      SHIFT: begin
        code_err_d = timeout;
      end
      default: begin
        letter_vld_d = 1'b0;
        code_err_d   = 1'b0;
      end
    endcase
  end

  // Symbol datapath: shift register, bit count (saturating at 12) and gap counter (holding at max).
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_bit) begin
            shift_q   <= CODE_START;
            bit_cnt_q <= CNT_ONE;
            gap_q     <= '0;
          end
        end
        SHIFT: begin
          if (NewBitIn) begin
            shift_q   <= {shift_q[CODE_WIDTH-2:0], DotDashIn};
            bit_cnt_q <= (bit_cnt_q >= CNT_FULL) ? CNT_FULL : bit_cnt_q + CNT_ONE;
            gap_q     <= '0;
          end else if (gap_q != GAP_MAX) begin
            gap_q <= gap_q + GAP_ONE;
          end
        end
        default: begin
          shift_q   <= shift_q;
          bit_cnt_q <= bit_cnt_q;
          gap_q     <= gap_q;
        end
      endcase
    end
  end

  // Registered result pulses; LetterOut only moves on a successful decode.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      LetterOut   <= '0;
      LetterValid <= 1'b0;
      CodeError   <= 1'b0;
    end else begin
      LetterValid <= letter_vld_d;
      CodeError   <= code_err_d;
      if (letter_vld_d) begin
        LetterOut <= lookup_letter;
      end
    end
  end

  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: scoreboard of expected result pulses with their exact cycle.
// Latency: checks LetterValid/CodeError at c+2 after the 12th strobe, timeout at s+9.
// Backpressure: exercises strobes in MATCH and a new symbol starting in the result cycle.
module tb_morse_decoder;

  logic       ClockIn = 1'b0;
  logic       Reset;
  logic       DotDashIn;
  logic       NewBitIn;
  logic [2:0] LetterOut;
  logic       LetterValid;
  logic       CodeError;
  logic       Busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    bit         is_err;
    logic [2:0] letter;
    int         at;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] letter_model = 3'd0;

  logic [11:0] tbl [8] = '{
    12'b101110000000, 12'b111010101000, 12'b111010111010, 12'b111010100000,
    12'b100000000000, 12'b101011101000, 12'b111011101000, 12'b101010100000
  };

  morse_decoder #(
    .CLOCK_FREQUENCY (8),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .ClockIn     (ClockIn),
    .Reset       (Reset),
    .DotDashIn   (DotDashIn),
    .NewBitIn    (NewBitIn),
    .LetterOut   (LetterOut),
    .LetterValid (LetterValid),
    .CodeError   (CodeError),
    .Busy        (Busy)
  );

  always #5 ClockIn = ~ClockIn;

  always @(posedge ClockIn) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic void ref_lookup(input logic [11:0] code, output bit hit, output logic [2:0] l);
    hit = 1'b0;
    l   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i] == code) begin
        hit = 1'b1;
        l   = 3'(i);
      end
    end
  endfunction

  // Scoreboard monitor: every result pulse must match the head of the queue in kind, cycle and letter.
  always @(negedge ClockIn) begin
    exp_t e;
    if (mon_en) begin
      if (LetterValid && CodeError) begin
        n_tests++;
        n_fail++;
        $display("FAIL both_pulses: LetterValid and CodeError both high at cycle %0d", cyc);
      end
      if (LetterValid || CodeError) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: LV=%0b CE=%0b at cycle %0d, none expected", LetterValid, CodeError, cyc);
        end else begin
          e = sb.pop_front();
          n_tests++;
          if (CodeError !== e.is_err) begin
            n_fail++;
            $display("FAIL pulse_kind: CodeError=%0b required %0b at cycle %0d", CodeError, e.is_err, cyc);
          end
          n_tests++;
          if (cyc !== e.at) begin
            n_fail++;
            $display("FAIL pulse_cycle: pulse at cycle %0d required %0d", cyc, e.at);
          end
          if (!e.is_err) letter_model = e.letter;
          n_tests++;
          if (LetterOut !== letter_model) begin
            n_fail++;
            $display("FAIL letter_out: LetterOut=%0d required %0d at cycle %0d", LetterOut, letter_model, cyc);
          end
        end
      end
    end
  end

  // Called at a negedge; drives one strobe for one cycle, then idles.
  task automatic send_bit(input logic b, input int idle);
    NewBitIn  = 1'b1;
    DotDashIn = b;
    @(negedge ClockIn);
    NewBitIn  = 1'b0;
    DotDashIn = 1'b0;
    repeat (idle) @(negedge ClockIn);
  endtask

  // Sends a full 12-bit symbol; returns at the negedge of the result cycle (c+2).
  task automatic send_symbol(input logic [11:0] code, input int idle, input bit poke_match);
    int         c;
    bit         hit;
    logic [2:0] l;
    c = 0;
    for (int i = 11; i >= 0; i--) begin
      if (i == 0) c = cyc;
      send_bit(code[i], (i == 0) ? 0 : idle);
    end
    ref_lookup(code, hit, l);
    sb.push_back('{!hit, l, c + 2});
    n_tests++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_match: Busy=%0b required 1 at cycle %0d", Busy, cyc);
    end
    if (poke_match) begin
      NewBitIn  = 1'b1;
      DotDashIn = 1'b1;
    end
    @(negedge ClockIn);
    NewBitIn  = 1'b0;
    DotDashIn = 1'b0;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    NewBitIn  = 1'b1;
    DotDashIn = 1'b1;
    repeat (3) @(negedge ClockIn);
    Reset        = 1'b0;
    NewBitIn     = 1'b0;
    DotDashIn    = 1'b0;
    letter_model = 3'd0;
    mon_en       = 1'b1;
    n_tests++;
    if (LetterOut !== 3'd0) begin n_fail++; $display("FAIL reset_letter: LetterOut=%0d required 0", LetterOut); end
    n_tests++;
    if (LetterValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: LetterValid=%0b required 0", LetterValid); end
    n_tests++;
    if (CodeError !== 1'b0) begin n_fail++; $display("FAIL reset_error: CodeError=%0b required 0", CodeError); end
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: Busy=%0b required 0", Busy); end
    @(negedge ClockIn);
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_priority_busy: Busy=%0b required 0", Busy); end
  endtask

  task automatic test_letter_c();
    send_bit(1'b1, 0);
    n_tests++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: Busy=%0b required 1", Busy); end
    Reset = 1'b1;
    @(negedge ClockIn);
    Reset = 1'b0;
    send_symbol(12'b111010111010, 1, 1'b0);
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall_c: Busy=%0b required 0", Busy); end
    repeat (3) @(negedge ClockIn);
    n_tests++;
    if (LetterOut !== 3'd2) begin n_fail++; $display("FAIL hold_c: LetterOut=%0d required 2", LetterOut); end
  endtask

  task automatic test_leading_zeros();
    repeat (3) send_bit(1'b0, 1);
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL zeros_busy: Busy=%0b required 0", Busy); end
    send_symbol(12'b100000000000, 0, 1'b0);
    repeat (2) @(negedge ClockIn);
  endtask

  task automatic test_unmatched();
    send_symbol(12'b110000000000, 1, 1'b0);
    repeat (2) @(negedge ClockIn);
    n_tests++;
    if (LetterOut !== 3'd4) begin n_fail++; $display("FAIL miss_hold: LetterOut=%0d required 4", LetterOut); end
  endtask

  task automatic test_timeout();
    logic [4:0] part;
    int         s;
    part = 5'b10111;
    s    = 0;
    for (int i = 4; i >= 0; i--) begin
      if (i == 0) s = cyc;
      send_bit(part[i], (i == 0) ? 0 : 1);
    end
    sb.push_back('{1'b1, 3'd0, s + 9});
    repeat (7) @(negedge ClockIn);
    n_tests++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_hold: Busy=%0b required 1 at s+8", Busy); end
    @(negedge ClockIn);
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_fall: Busy=%0b required 0 at s+9", Busy); end
    repeat (3) @(negedge ClockIn);
    send_symbol(12'b101010100000, 1, 1'b0);
    repeat (2) @(negedge ClockIn);
  endtask

  task automatic test_reset_abort();
    logic [5:0] part;
    part = 6'b111011;
    for (int i = 5; i >= 0; i--) send_bit(part[i], 1);
    Reset = 1'b1;
    @(negedge ClockIn);
    Reset        = 1'b0;
    letter_model = 3'd0;
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: Busy=%0b required 0", Busy); end
    n_tests++;
    if (LetterOut !== 3'd0) begin n_fail++; $display("FAIL abort_letter: LetterOut=%0d required 0", LetterOut); end
    repeat (2) @(negedge ClockIn);
    send_symbol(12'b111011101000, 2, 1'b0);
    repeat (2) @(negedge ClockIn);
  endtask

  task automatic test_back_to_back();
    send_symbol(12'b100000000000, 0, 1'b1);
    send_symbol(12'b111010100000, 0, 1'b0);
    send_symbol(12'b101110000000, 0, 1'b0);
    repeat (2) @(negedge ClockIn);
  endtask

  task automatic test_loopback();
    for (int l = 0; l < 8; l++) begin
      send_symbol(tbl[l], 2, 1'b0);
      send_bit(1'b0, 2);
      send_bit(1'b0, 2);
    end
  endtask

  task automatic test_drain();
    int budget;
    budget = 30;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge ClockIn);
      budget--;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected pulses never seen, required 0", sb.size());
    end
  endtask

  initial begin
    Reset     = 1'b1;
    NewBitIn  = 1'b0;
    DotDashIn = 1'b0;
    @(negedge ClockIn);
    test_reset();
    test_letter_c();
    test_leading_zeros();
    test_unmatched();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    test_loopback();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
